// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial add/subtract sequencer.
// A single full-adder slice is stepped LSB-first over two latched WIDTH-bit
// operands, one bit per clock, through a registered carry. Reports the
// sum/difference, the carry out of the MSB (1 = no borrow for subtract) and
// signed two's-complement overflow.
// Optional build macro: SERIAL_ADDSUB_SAT_EN -- saturates Result on overflow
// (Cout and Overflow still report the unsaturated values).
module serial_addsub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned RW = WIDTH - 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           accept_c;
  logic           last_c;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [RW-1:0]    res_sh;
  logic             carry;
  logic [CW-1:0]    count;

  logic             sum_bit_c;
  logic             carry_nxt_c;
  logic             ovf_c;
  logic [WIDTH-1:0] res_final_c;

`ifdef SERIAL_ADDSUB_SAT_EN
  logic             a_msb;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: accept only from IDLE, finish on the last bit
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    last_c    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_c  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (count == CW'(WIDTH - 1)) begin
          last_c    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Full-adder slice on the current LSBs and the registered carry
  always_comb begin
    sum_bit_c   = op_a[0] ^ op_b[0] ^ carry;
    carry_nxt_c = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    // carry here is the carry into the MSB when the last bit is processed
    ovf_c       = carry ^ carry_nxt_c;
  end

  // Final result: last sum bit lands in the MSB above the shifted-in bits
  always_comb begin
    res_final_c = {sum_bit_c, res_sh};
`ifdef SERIAL_ADDSUB_SAT_EN
    if (ovf_c) begin
      res_final_c = a_msb ? {1'b1, {RW{1'b0}}} : {1'b0, {RW{1'b1}}};
    end
`endif
  end

  // Operand latch and LSB-first shift datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
    end else if (accept_c) begin
      op_a   <= a;
      op_b   <= sub ? ~b : b;
      res_sh <= '0;
      carry  <= sub;
      count  <= '0;
    end else if (state == RUN) begin
      op_a   <= op_a >> 1;
      op_b   <= op_b >> 1;
      res_sh <= RW'({sum_bit_c, res_sh} >> 1);
      carry  <= carry_nxt_c;
      count  <= count + CW'(1);
    end
  end

`ifdef SERIAL_ADDSUB_SAT_EN
  // Sign of operand A, kept for the saturation direction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
    end else if (accept_c) begin
      a_msb <= a[WIDTH-1];
    end
  end
`endif

  // Status outputs: busy follows the next state, done pulses on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= last_c;
    end
  end

  // Result outputs update only on completion and hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (last_c) begin
      result   <= res_final_c;
      cout     <= carry_nxt_c;
      overflow <= ovf_c;
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Bench for serial_addsub_ctrl (WIDTH=8): directed steps plus a few random
// operations; expected results are queued at accept and popped on done.
module tb_serial_addsub_ctrl;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int n_assert = 0;
  int n_fail   = 0;
  exp_t sb_q[$];

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: parallel add of A and (possibly inverted) B with carry-in
  function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                 input logic si);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   s;
    bb  = si ? ~bi : bi;
    s   = {1'b0, ai} + {1'b0, bb} + (W + 1)'(si);
    e.r = s[W-1:0];
    e.c = s[W];
    e.v = (ai[W-1] == bb[W-1]) && (s[W-1] != ai[W-1]);
`ifdef SERIAL_ADDSUB_SAT_EN
    if (e.v) e.r = ai[W-1] ? 8'h80 : 8'h7F;
`endif
    return e;
  endfunction

  task automatic chk(input logic [31:0] obs, input logic [31:0 ] expv, input string tag);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: compare outputs against the oldest queued expectation on done
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk(32'(1), 32'(0), "unexpected_done");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk(32'(result),   32'(e.r), "result");
        chk(32'(cout),     32'(e.c), "cout");
        chk(32'(overflow), 32'(e.v), "overflow");
      end
    end
  end

  // One operation with cycle-accurate busy/done/hold checks; called at edge+1
  task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si);
    logic [W-1:0] prev;
    prev  = result;
    chk(32'(busy), 32'(0), "idle_before_start");
    a     = ai;
    b     = bi;
    sub   = si;
    start = 1'b1;
    sb_q.push_back(model(ai, bi, si));
    @(posedge clk); #1;
    start = 1'b0;
    a     = ~ai;
    b     = ~bi;
    sub   = ~si;
    chk(32'(busy), 32'(1), "busy_after_accept");
    for (int i = 1; i < int'(W); i++) begin
      @(posedge clk); #1;
      chk(32'({busy, done}), 32'(2'b10), "busy_during_run");
      chk(32'(result), 32'(prev), "result_hold");
    end
    @(posedge clk); #1;
    chk(32'({busy, done}), 32'(2'b01), "done_at_t0_plus_w");
    @(posedge clk); #1;
    chk(32'(done), 32'(0), "done_one_cycle");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no end expected end");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    chk(32'({busy, done, result, cout, overflow}), 32'(0), "reset_outputs");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed add/subtract/overflow cases
    do_op(8'h3C, 8'h05, 1'b0);
    do_op(8'h05, 8'h07, 1'b1);
    do_op(8'h07, 8'h05, 1'b1);
    do_op(8'h7F, 8'h01, 1'b0);
    do_op(8'h80, 8'h01, 1'b1);
    do_op(8'hFF, 8'h01, 1'b0);
    do_op(8'h00, 8'h00, 1'b1);

    // Start during RUN is ignored
    a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
    sb_q.push_back(model(8'h10, 8'h20, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    for (int i = 4; i < int'(W); i++) begin
      @(posedge clk); #1;
      chk(32'({busy, done}), 32'(2'b10), "ignored_start_busy");
    end
    @(posedge clk); #1;
    chk(32'({busy, done}), 32'(2'b01), "ignored_start_done");
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk(32'({busy, done}), 32'(0), "no_second_done");
    end

    // Asynchronous reset in the middle of an operation
    a = 8'h11; b = 8'h22; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk(32'({busy, done, result, cout, overflow}), 32'(0), "reset_mid_op");
    #3;
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      chk(32'({busy, done}), 32'(0), "no_done_after_reset");
    end

    // Back-to-back with start held: done every W+1 cycles
    a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back(model(8'h01, 8'h01, 1'b0));
      @(posedge clk); #1;
      chk(32'({busy, done}), 32'(2'b10), "b2b_accept");
      for (int i = 1; i < int'(W); i++) begin
        @(posedge clk); #1;
        chk(32'({busy, done}), 32'(2'b10), "b2b_busy");
      end
      @(posedge clk); #1;
      chk(32'({busy, done}), 32'(2'b01), "b2b_done");
      if (k == 2) start = 1'b0;
    end
    @(posedge clk); #1;
    chk(32'({busy, done}), 32'(0), "b2b_stop");

    // Random operations
    for (int k = 0; k < 8; k++) begin
      do_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)));
    end

    chk(32'(sb_q.size()), 32'(0), "scoreboard_drained");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
- Bit-serial add/subtract sequencer built around one 1-bit full-adder slice: the Sum/Cout function of A, B and Cin.
- Latches two WIDTH-bit operands, then steps the full adder LSB-first, one bit per clock, through a registered carry.
- Reports sum/difference, carry/borrow and signed overflow.
- Used where area matters more than latency; it is the sequential counterpart of the ripple adder/subtractor.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range is 2 or more.

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- Start  input  1  request; sampled only when idle
- Sub  input  1  0 = A+B, 1 = A-B; latched with operands
- A  input  WIDTH  operand A; latched on accept
- B  input  WIDTH  operand B; latched on accept
- Busy  output  1  high while an operation is in progress
- Done  output  1  one-cycle pulse: result outputs valid
- Result  output  WIDTH  sum/difference
- Cout  output  1  final carry out of MSB; for subtract, 1 = no borrow
- Overflow  output  1  signed two's-complement overflow

Behaviour:
- Reset (Rst_n low, asynchronous): state IDLE; Busy=0, Done=0, Result=0, Cout=0, Overflow=0; bit counter, carry and shift registers cleared. Takes effect immediately, including mid-operation; the aborted operation never produces Done.
- States: IDLE, RUN.
- IDLE to RUN on a rising edge with Start=1. At that edge (t0):
  - opA <= A; opB <= Sub ? ~B : B
  - carry <= Sub; count <= 0; subLatched <= Sub; Busy <= 1
- RUN, each edge:
  - bit = opA[0] ^ opB[0] ^ carry
  - carry <= majority(opA[0], opB[0], carry)
  - opA, opB shift right by 1
  - bit shifts into the result shift register from the MSB side
  - count <= count + 1
  - on the edge where count == WIDTH-1, record carry-in-to-MSB (the carry value at that edge) for overflow
- On the edge processing count == WIDTH-1 (edge t0+WIDTH):
  - state <= IDLE; Busy <= 0; Done <= 1
  - Result <= final shifted value; Cout <= final carry
  - Overflow <= carry-into-MSB XOR carry-out-of-MSB
- Done is high for exactly one cycle (t0+WIDTH to t0+WIDTH+1).
- Result, Cout and Overflow hold their values until the next completion; they do not change during RUN.
- Latency: Done rises WIDTH clock edges after the accept edge. Max throughput is one operation per WIDTH+1 cycles.
- Start while Busy=1 is ignored. Operand, Sub or Start changes during RUN have no effect.
- Start high during the Done cycle is accepted (state is IDLE). Done then clears on that edge and Busy rises on the same edge.
- Counter is $clog2(WIDTH)+1 bits wide; no wrap-around within one operation.

Optional Feature:
- Macro: SERIAL_ADDSUB_SAT_EN
- Defined: on completion with overflow, Result is saturated:
  - latched opA MSB = 1: Result = {1'b1, {WIDTH-1{1'b0}}}, i.e. min negative
  - latched opA MSB = 0: Result = {1'b0, {WIDTH-1{1'b1}}}, i.e. max positive
  - the original A MSB is captured at accept
  - Overflow and Cout still report the unsaturated values
- Not defined: Result is always the wrapped WIDTH-bit value; no extra logic.

Test Plan (WIDTH=8):
- Add: A=8'h3C, B=8'h05, Sub=0, Start pulse at t0 -> Busy high for 8 cycles; Done pulse at t0+8; Result=8'h41, Cout=0, Overflow=0.
- Subtract: A=8'h05, B=8'h07, Sub=1 -> Result=8'hFE, Cout=0 (borrow), Overflow=0. Then A=8'h07, B=8'h05 -> Result=8'h02, Cout=1.
- Overflow: 8'h7F+8'h01 -> Result=8'h80, Overflow=1, Cout=0; with SERIAL_ADDSUB_SAT_EN, Result=8'h7F. Also 8'h80-8'h01 -> Result=8'h7F, Overflow=1, Cout=1; with SAT_EN, Result=8'h80.
- Ignored start: accept 8'h10+8'h20; at t0+3 drive Start=1 with A=8'hFF, B=8'hFF -> single Done at t0+8 with Result=8'h30; no second Done.
- Reset mid-op: accept 8'h11+8'h22; drop Rst_n between t0+4 and t0+5 -> Busy, Done, Result, Cout and Overflow all 0 immediately. After release there is no Done until a new Start.
- Back-to-back: hold Start=1 with A=8'h01, B=8'h01 -> Done pulses every 9 cycles; Result=8'h02 each time; Busy low only during Done cycles.
